// File: rtl/pcm_to_i2s_if.sv
// pcm_to_i2s_if
// Carries the PCM sample-pair handshake between a sample source and the
// I2S serializer.
//   data_left    : left-channel PCM sample, two's complement
//   data_right   : right-channel PCM sample, two's complement
//   sample_valid : source presents a valid left/right pair
//   sample_ready : serializer holding register is empty and can take a pair
// modport master : sample source side
// modport slave  : serializer side
interface pcm_to_i2s_if #(
   parameter int NUMBER_OF_BITS = 8
);
   logic [NUMBER_OF_BITS-1:0] data_left;
   logic [NUMBER_OF_BITS-1:0] data_right;
   logic                      sample_valid;
   logic                      sample_ready;

   modport master (
      output data_left,
      output data_right,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  data_left,
      input  data_right,
      input  sample_valid,
      output sample_ready
   );
endinterface

// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s
// Serializes left/right PCM sample pairs into an I2S stream clocked by the
// bit clock. Each channel slot is SLOT_BITS bit clocks long. The sample MSB
// goes out one bit clock after the slot starts (I2S one-bit delay). The
// remaining bits follow MSB first, and the rest of the slot is padded
// with zeros. Pairs enter through a single-entry holding register. At the
// end of every right slot that register is moved into the frame register.
// If the holding register is empty at that point, a zero frame is sent and
// underrun pulses for one cycle.
//   clk      : bit clock, all state advances on the rising edge
//   reset    : asynchronous, active-high
//   pcm      : sample-pair handshake (slave side)
//   ws       : word select, 0 = left slot, 1 = right slot (registered)
//   sd       : serial data (registered)
//   underrun : one-cycle pulse when a frame starts with no sample pending
// SLOT_BITS must be at least NUMBER_OF_BITS+1 so that a full word plus the
// one-bit delay fits in a slot.
//
// Holding-register FSM
//   state      | meaning
//   HOLD_EMPTY | no pair pending; sample_ready = 1
//   HOLD_FULL  | pair captured, waiting for the next frame boundary
module pcm_to_i2s #(
   parameter int NUMBER_OF_BITS = 8,
   parameter int SLOT_BITS      = 16
) (
   input  logic         clk,
   input  logic         reset,
   pcm_to_i2s_if.slave  pcm,
   output logic         ws,
   output logic         sd,
   output logic         underrun
);

   localparam int CNT_W = (SLOT_BITS > 2) ? $clog2(SLOT_BITS) : 1;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

   hold_state_t               r_hold_state;
   hold_state_t               w_hold_state_next;

   logic [CNT_W-1:0]          r_cnt;
   logic                      r_ws;
   logic                      r_sd;
   logic                      r_underrun;
   logic [NUMBER_OF_BITS-1:0] r_hold_left;
   logic [NUMBER_OF_BITS-1:0] r_hold_right;
   logic [NUMBER_OF_BITS-1:0] r_frame_left;
   logic [NUMBER_OF_BITS-1:0] r_frame_right;

   logic                      w_slot_last;
   logic                      w_transfer;
   logic                      w_accept;
   logic                      w_frame_from_hold;
   logic                      w_underrun_next;
   logic [CNT_W-1:0]          w_cnt_next;
   logic                      w_ws_next;
   logic [NUMBER_OF_BITS-1:0] w_sd_word;
   logic [CNT_W-1:0]          w_bit_idx;
   logic                      w_sd_next;

   // Slot timing: free-running counter, ws flips on the wrap edge
   always_comb begin
      w_slot_last = (r_cnt == CNT_W'(SLOT_BITS - 1));
      w_transfer  = w_slot_last && r_ws;
      w_cnt_next  = w_slot_last ? '0 : (r_cnt + CNT_W'(1));
      w_ws_next   = r_ws ^ w_slot_last;
   end

   // Holding-register FSM: next state and frame-boundary decisions
   always_comb begin
      w_hold_state_next = r_hold_state;
      w_accept          = 1'b0;
      w_frame_from_hold = 1'b0;
      w_underrun_next   = 1'b0;
      case (r_hold_state)
         HOLD_EMPTY: begin
            w_accept = pcm.sample_valid;
            // A pair accepted on the transfer edge itself is too late for
            // this frame; it waits for the next one.
            w_underrun_next = w_transfer;
            if (w_accept) begin
               w_hold_state_next = HOLD_FULL;
            end
         end
         HOLD_FULL: begin
            w_frame_from_hold = w_transfer;
            if (w_transfer) begin
               w_hold_state_next = HOLD_EMPTY;
            end
         end
         default: begin
            w_hold_state_next = HOLD_EMPTY;
         end
      endcase
   end

   // Serial data for the coming period. The frame register only changes on
   // transfer edges, where the next count is 0 and sd is forced low, so the
   // current frame contents are always the right ones to look at here.
   always_comb begin
      w_sd_word = w_ws_next ? r_frame_right : r_frame_left;
      w_bit_idx = CNT_W'(NUMBER_OF_BITS) - w_cnt_next;
      w_sd_next = 1'b0;
      if ((w_cnt_next != '0) && (w_cnt_next <= CNT_W'(NUMBER_OF_BITS))) begin
         w_sd_next = |(w_sd_word & (NUMBER_OF_BITS'(1) << w_bit_idx));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold_state <= HOLD_EMPTY;
      end else begin
         r_hold_state <= w_hold_state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt      <= '0;
         r_ws       <= 1'b0;
         r_sd       <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_next;
         r_ws       <= w_ws_next;
         r_sd       <= w_sd_next;
         r_underrun <= w_underrun_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold_left  <= '0;
         r_hold_right <= '0;
      end else if (w_accept) begin
         r_hold_left  <= pcm.data_left;
         r_hold_right <= pcm.data_right;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_left  <= '0;
         r_frame_right <= '0;
      end else if (w_transfer) begin
         r_frame_left  <= w_frame_from_hold ? r_hold_left  : '0;
         r_frame_right <= w_frame_from_hold ? r_hold_right : '0;
      end
   end

   assign pcm.sample_ready = (r_hold_state == HOLD_EMPTY);
   assign ws               = r_ws;
   assign sd               = r_sd;
   assign underrun         = r_underrun;

endmodule

// File: tb/tb_pcm_to_i2s.sv
module tb_pcm_to_i2s;
   localparam int NB   = 8;
   localparam int SLOT = 16;
   localparam int FRM  = 2 * SLOT;

   typedef struct {
      logic [NB-1:0] l;
      logic [NB-1:0] r;
      logic          ur;
   } frame_t;

   logic clk;
   logic reset;
   logic ws;
   logic sd;
   logic underrun;

   pcm_to_i2s_if #(.NUMBER_OF_BITS(NB)) pcm ();

   pcm_to_i2s #(
      .NUMBER_OF_BITS(NB),
      .SLOT_BITS     (SLOT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .pcm     (pcm),
      .ws      (ws),
      .sd      (sd),
      .underrun(underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int frames_checked = 0;
   int exp_frames = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: period index, one pending pair, expected frames.
   int            k;
   logic          m_full;
   logic [NB-1:0] m_l, m_r;
   frame_t        exp_q[$];

   always @(posedge clk or posedge reset) begin
      frame_t f;
      if (reset) begin
         k      <= 0;
         m_full <= 1'b0;
         exp_q.delete();
         f.l = '0; f.r = '0; f.ur = 1'b0;
         exp_q.push_back(f);
      end else begin
         k <= k + 1;
         if (k % FRM == FRM - 1) begin
            // a new frame begins: send the pending pair, or zeros on underrun
            f.l  = m_full ? m_l : '0;
            f.r  = m_full ? m_r : '0;
            f.ur = !m_full;
            exp_q.push_back(f);
            if (m_full) m_full <= 1'b0;
         end
         if (pcm.sample_valid && !m_full) begin
            m_l    <= pcm.data_left;
            m_r    <= pcm.data_right;
            m_full <= 1'b1;
         end
      end
   end

   // Monitor: samples once per period on the falling edge, rebuilds each
   // frame from sd and compares against the expected-frame queue.
   logic [NB-1:0] cur_l, cur_r;
   logic          bad_sd, bad_ur, ur_first;

   always @(negedge clk) begin
      int   c;
      logic ws_exp;
      frame_t f;
      if (reset) begin
         chk("reset_ws", ws, 0);
         chk("reset_sd", sd, 0);
         chk("reset_ready", pcm.sample_ready, 1);
         chk("reset_underrun", underrun, 0);
         cur_l = '0; cur_r = '0; bad_sd = 0; bad_ur = 0; ur_first = 0;
      end else begin
         c      = k % SLOT;
         ws_exp = ((k / SLOT) % 2) == 1;
         chk("ws", ws, ws_exp);
         chk("sample_ready", pcm.sample_ready, !m_full);
         if (c >= 1 && c <= NB) begin
            if (ws_exp) cur_r[NB-c] = sd;
            else        cur_l[NB-c] = sd;
         end else if (sd !== 1'b0) begin
            bad_sd = 1;
         end
         if (k % FRM == 0) ur_first = underrun;
         else if (underrun !== 1'b0) bad_ur = 1;
         if (k % FRM == FRM - 1) begin
            if (exp_q.size() == 0) begin
               chk("frame_expected_present", 0, 1);
            end else begin
               f = exp_q.pop_front();
               chk("frame_left", cur_l, f.l);
               chk("frame_right", cur_r, f.r);
               chk("frame_underrun", ur_first, f.ur);
            end
            chk("sd_padding_zero", bad_sd, 0);
            chk("underrun_one_cycle", bad_ur, 0);
            frames_checked++;
            cur_l = '0; cur_r = '0; bad_sd = 0; bad_ur = 0; ur_first = 0;
         end
      end
   end

   task automatic apply_reset();
      #1;
      pcm.sample_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   // Drive the inputs for the current period k according to the scenario.
   task automatic drive_period(input int mode);
      logic v;
      case (mode)
         0:       v = (k == 3);
         1:       v = (k >= 1);
         2:       v = (k == 40);
         3:       v = (k >= 31);
         4:       v = ($urandom_range(0, 1) == 1);
         5:       v = (k == 3 || k == 35);
         default: v = 1'b0;
      endcase
      pcm.sample_valid = v;
      if (mode == 0) begin
         pcm.data_left  = 8'hA5;
         pcm.data_right = 8'h3C;
      end else begin
         pcm.data_left  = NB'($urandom);
         pcm.data_right = NB'($urandom);
      end
   endtask

   task automatic run_scenario(input int mode, input int nframes);
      apply_reset();
      exp_frames += nframes;
      for (int p = 0; p < FRM * nframes; p++) begin
         @(negedge clk);
         drive_period(mode);
      end
   endtask

   task automatic run_reset_midframe();
      apply_reset();
      for (int p = 0; p <= 40; p++) begin
         @(negedge clk);
         drive_period(5);
      end
      exp_frames += 1;
      #1 reset = 1'b1;
      #1;
      chk("async_reset_ws", ws, 0);
      chk("async_reset_sd", sd, 0);
      chk("async_reset_ready", pcm.sample_ready, 1);
      chk("async_reset_underrun", underrun, 0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      exp_frames += 2;
      for (int p = 0; p < FRM * 2; p++) begin
         @(negedge clk);
         drive_period(6);
      end
   endtask

   initial begin
      reset            = 1'b1;
      pcm.sample_valid = 1'b0;
      pcm.data_left    = '0;
      pcm.data_right   = '0;
      run_scenario(0, 3);   // single pair A5/3C in P3
      run_scenario(1, 4);   // continuous valid, back-pressure
      run_scenario(2, 3);   // underrun, late pair in P40
      run_scenario(3, 3);   // accept on the transfer edge
      run_scenario(4, 8);   // random valid and data
      run_reset_midframe(); // reset in P40 with a pair pending
      #1;
      chk("frames_checked", frames_checked, exp_frames);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
